// File: rtl/conv_code_pkg.sv
// Shared code definitions for the rate-1/2, K=4 convolutional encoder and its Viterbi decoder.
package conv_code_pkg;

    localparam int unsigned NUM_STATES = 8;
    localparam int unsigned K          = 4;
    localparam int unsigned SW         = K - 1;
    localparam logic [K-1:0] G1        = 4'b1111;  // 17 octal
    localparam logic [K-1:0] G0        = 4'b1101;  // 15 octal

    // Framer FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    typedef logic [1:0]    fsm_state_t;
    typedef logic [SW-1:0] trellis_state_t;   // {s2, s1, s0}, s2 = most recent bit
    typedef logic [1:0]    symbol_t;          // {o1, o0}

    // Trellis transition: new bit enters at s2
    function automatic trellis_state_t next_state(input trellis_state_t s, input logic b);
        return {b, s[SW-1:1]};
    endfunction

    // Channel symbol for input bit b leaving state s
    function automatic symbol_t symbol_for(input trellis_state_t s, input logic b);
        logic [K-1:0] r;
        r = {b, s};
        return {^(r & G1), ^(r & G0)};
    endfunction

endpackage

// File: rtl/conv_encoder_core.sv
// Three-bit shift register with generator XOR taps; symbol output is combinational.
import conv_code_pkg::*;

module conv_encoder_core (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           clr,
    input  logic           code_bit,
    output symbol_t        sym_c,
    output trellis_state_t state
);

    // Symbol for the bit being consumed from the current state
    always_comb begin
        sym_c = symbol_for(state, code_bit);
    end

    // Clear takes priority so a tail bit and a new-frame clear can share an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (clr) begin
            state <= '0;
        end else if (en) begin
            state <= next_state(state, code_bit);
        end
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frames Z-bit words into Z+1 encoded symbols (LSB first, one zero tail bit).
import conv_code_pkg::*;

module conv_encoder_framer #(
    parameter int unsigned Z = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [Z-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic [1:0]   sym_out,
    output logic         sym_valid,
    output logic         frame_start,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(Z + 1);

    fsm_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [Z-1:0]   data_buf, data_buf_nxt;
    symbol_t        sym_nxt;
    logic           sym_valid_nxt;
    logic           frame_start_nxt;
    logic           enc_en;
    logic           enc_clr;
    logic           enc_bit;
    symbol_t        enc_sym_c;
    trellis_state_t enc_state;

    conv_encoder_core u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (enc_en),
        .clr      (enc_clr),
        .code_bit (enc_bit),
        .sym_c    (enc_sym_c),
        .state    (enc_state)
    );

    // Next-state and output decode; buffer shifts right so bit k is always at [0]
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        data_buf_nxt    = data_buf;
        sym_nxt         = 2'b00;
        sym_valid_nxt   = 1'b0;
        frame_start_nxt = 1'b0;
        enc_en          = 1'b0;
        enc_clr         = 1'b0;
        enc_bit         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    data_buf_nxt = data_in;
                    cnt_nxt      = '0;
                    enc_clr      = 1'b1;
                    state_nxt    = ST_DATA;
                end
            end
            ST_DATA: begin
                enc_en          = 1'b1;
                enc_bit         = data_buf[0];
                data_buf_nxt    = data_buf >> 1;
                sym_nxt         = enc_sym_c;
                sym_valid_nxt   = 1'b1;
                frame_start_nxt = (cnt == '0);
                if (cnt == CNT_W'(Z - 1)) begin
                    state_nxt = ST_TAIL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_TAIL: begin
                enc_en        = 1'b1;
                enc_bit       = 1'b0;
                sym_nxt       = enc_sym_c;
                sym_valid_nxt = 1'b1;
                if (data_valid) begin
                    data_buf_nxt = data_in;
                    cnt_nxt      = '0;
                    enc_clr      = 1'b1;
                    state_nxt    = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; ready/busy follow the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            data_buf    <= '0;
            sym_out     <= 2'b00;
            sym_valid   <= 1'b0;
            frame_start <= 1'b0;
            data_ready  <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            data_buf    <= data_buf_nxt;
            sym_out     <= sym_nxt;
            sym_valid   <= sym_valid_nxt;
            frame_start <= frame_start_nxt;
            data_ready  <= (state_nxt != ST_DATA);
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule
